// File: rtl/day11_pkg.sv
// day11_pkg: shared state type and size helpers for the day-11 path combiner
package day11_pkg;
  typedef enum logic [1:0] {COLLECT, COMPUTE, DONE} day11_state_e;
  function automatic int slots_f(input int groups, input int factors);
    return 1 + groups * factors;
  endfunction
  function automatic int idxw_f(input int groups, input int factors);
    return $clog2(slots_f(groups, factors) + 1);
  endfunction
endpackage

// File: rtl/day11_seq_mac.sv
// day11_seq_mac: one-multiply-per-cycle sum of group products; overflow tracking under DAY11_OVERFLOW_DETECT_EN
module day11_seq_mac
  import day11_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int GROUPS = 2,
  parameter int FACTORS = 3,
  localparam int N = GROUPS * FACTORS,
  localparam int KW = idxw_f(GROUPS, FACTORS),
  localparam int FW = $clog2(FACTORS + 1)
) (
  input  logic             clk,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic [KW-1:0]    k,
  output logic             last,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);
  logic [WIDTH-1:0] prod, acc_q, prod_next;
  logic [FW-1:0] f;
  logic fl, step_ovf;
  assign fl = f == FW'(FACTORS - 1);
  assign last = busy && k == KW'(N - 1);
`ifdef DAY11_OVERFLOW_DETECT_EN
  logic [2*WIDTH-1:0] wide;
  logic [WIDTH:0] sum;
  // full-width multiply and carry-out accumulate so lost bits can be flagged
  always_comb begin
    wide = {{WIDTH{1'b0}}, prod} * {{WIDTH{1'b0}}, din};
    prod_next = f == '0 ? din : wide[WIDTH-1:0];
    sum = {1'b0, acc_q} + {1'b0, prod_next};
    acc = fl ? sum[WIDTH-1:0] : acc_q;
    step_ovf = (f != '0 && |wide[2*WIDTH-1:WIDTH]) || (fl && sum[WIDTH]);
  end
  // sticky overflow, cleared only by abort
  always_ff @(posedge clk)
    if (abort) ovf <= 1'b0;
    else if (busy && step_ovf) ovf <= 1'b1;
`else
  // low-half multiply and wrapping accumulate
  always_comb begin
    prod_next = f == '0 ? din : prod * din;
    acc = fl ? acc_q + prod_next : acc_q;
    step_ovf = 1'b0;
  end
  assign ovf = step_ovf;
`endif
  // step sequencer: k walks the slots, f tracks position within the group
  always_ff @(posedge clk)
    if (abort || start) begin
      busy <= start && !abort;
      k <= '0;
      f <= '0;
      prod <= '0;
      acc_q <= '0;
    end else if (busy) begin
      prod <= prod_next;
      acc_q <= acc;
      k <= k + KW'(1);
      f <= fl ? '0 : f + FW'(1);
      busy <= !last;
    end
endmodule

// File: rtl/day11_path_combiner.sv
// day11_path_combiner: collects 1+GROUPS*FACTORS counts, reports slot 0 and sum of group products; overflow under DAY11_OVERFLOW_DETECT_EN
module day11_path_combiner
  import day11_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int GROUPS = 2,
  parameter int FACTORS = 3,
  localparam int SLOTS = slots_f(GROUPS, FACTORS),
  localparam int IDXW = idxw_f(GROUPS, FACTORS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] count,
  input  logic             count_valid,
  input  logic             count_last,
  output logic             ready,
  output logic             done_,
  output logic [WIDTH-1:0] part1_result,
  output logic [WIDTH-1:0] part2_result,
  output logic [IDXW-1:0]  idx,
  output logic             len_err,
  output logic             overflow
);
  day11_state_e state, state_n;
  logic [WIDTH-1:0] slot [2**IDXW];
  logic restart, beat, in_rng, last_ok, start, mac_busy, mac_last;
  logic [IDXW-1:0] mac_k, kp1;
  logic [WIDTH-1:0] mac_acc;
  assign restart = clear || load;
  assign ready = state == COLLECT;
  assign done_ = state == DONE;
  assign part1_result = slot[0];
  assign beat = ready && count_valid;
  assign in_rng = idx < IDXW'(SLOTS);
  assign last_ok = idx == IDXW'(SLOTS - 1) && !len_err;
  assign start = beat && count_last && last_ok;
  assign kp1 = mac_k + IDXW'(1);
  day11_seq_mac #(.WIDTH(WIDTH), .GROUPS(GROUPS), .FACTORS(FACTORS)) u_mac (
    .clk(clock),
    .abort(restart),
    .start(start),
    .din(slot[kp1]),
    .busy(mac_busy),
    .k(mac_k),
    .last(mac_last),
    .acc(mac_acc),
    .ovf(overflow)
  );
  // next state: last beat picks compute or error-done, final mac step ends compute
  always_comb
    state_n = (ready && beat && count_last) ? (last_ok ? COMPUTE : DONE) :
              (state == COMPUTE && mac_busy && mac_last) ? DONE : state;
  // state register, restart wins from any state
  always_ff @(posedge clock)
    state <= restart ? COLLECT : state_n;
  // slot file, beat index, length error and final part-2 capture
  always_ff @(posedge clock)
    if (restart) begin
      idx <= '0;
      len_err <= 1'b0;
      part2_result <= '0;
      for (int i = 0; i < 2**IDXW; i++) slot[i] <= '0;
    end else begin
      if (beat && in_rng) begin
        slot[idx] <= count;
        idx <= idx + IDXW'(1);
      end
      if (beat && (!in_rng || (count_last && !last_ok))) len_err <= 1'b1;
      if (state == COMPUTE && mac_last) part2_result <= mac_acc;
    end
endmodule
